// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = in1 - in2 - bin, one bit per clock,
// LSB first, with a start/done handshake and held borrow-out / signed-overflow flags.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Only WIDTH-1 partial bits are stored; the final bit goes straight into diff.
    logic [WIDTH-2:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic d_bit;
    logic borrow_nxt;

    assign d_bit      = a_q[0] ^ b_q[0] ^ borrow_q;
    assign borrow_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    a_d      = in1;
                    b_d      = in2;
                    borrow_d = bin;
                    cnt_d    = '0;
                    sign_a_d = in1[WIDTH-1];
                    sign_b_d = in2[WIDTH-1];
                end
            end
            RUN: begin
                a_d             = a_q >> 1;
                b_d             = b_q >> 1;
                borrow_d        = borrow_nxt;
                res_d           = res_q >> 1;
                res_d[WIDTH-2]  = d_bit;
                cnt_d           = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    diff_d  = {d_bit, res_q};
                    bout_d  = borrow_nxt;
                    // Overflow only when operand signs differ and the result sign left the minuend's.
                    ovf_d   = (sign_a_q != sign_b_q) && (d_bit != sign_a_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, handshake corner
// cases, mid-run reset, back-to-back starts and random operands against an arithmetic model.
`timescale 1ns/1ps
module tb_serial_subtractor;

    localparam int W = 8;

    logic         sys_clk;
    logic         sys_rst;
    logic         start;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (start),
        .in1     (in1),
        .in2     (in2),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bout    (bout),
        .ovf     (ovf)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [W-1:0] in1;
        logic [W-1:0] in2;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] in1;
        logic [W-1:0] in2;
        logic         bin;
    } op_t;

    vec_t vecs[8];
    op_t  pend[$];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Arithmetic reference: plain integer subtraction, unsigned and signed views.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int us;
        int ss;
        us = int'(a) - int'(b) - int'(bi);
        ss = int'($signed(a)) - int'($signed(b)) - int'(bi);
        d  = us[W-1:0];
        bo = (us < 0);
        ov = (ss < -(2 ** (W - 1))) || (ss > (2 ** (W - 1)) - 1);
    endtask

    // One complete transaction from IDLE, checking handshake timing and the result.
    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bi, input logic [W-1:0] ed, input logic eb, input logic eo);
        int done_cnt;
        done_cnt = 0;
        in1 = a; in2 = b; bin = bi; start = 1'b1;
        tick();
        start = 1'b0;
        in1 = W'($urandom); in2 = W'($urandom); bin = 1'($urandom);
        chk({nm, "_busy_rise"}, 32'(busy), 32'd1);
        chk({nm, "_done_early"}, 32'(done), 32'd0);
        for (int j = 1; j <= W; j++) begin
            tick();
            if (done) done_cnt++;
            if (j == W) chk({nm, "_done_at_w"}, 32'(done), 32'd1);
        end
        chk({nm, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({nm, "_diff"}, 32'(diff), 32'(ed));
        chk({nm, "_bout"}, 32'(bout), 32'(eb));
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
        tick();
        chk({nm, "_busy_fall"}, 32'(busy), 32'd0);
        chk({nm, "_done_fall"}, 32'(done), 32'd0);
        chk({nm, "_diff_hold"}, 32'(diff), 32'(ed));
        $display("op %s: 0x%02h - 0x%02h - %0d -> diff=0x%02h bout=%0d ovf=%0d",
                 nm, a, b, bi, diff, bout, ovf);
    endtask

    initial begin
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        int           dcnt;
        op_t          op;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        sys_rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; bin = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        sys_rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].in1, vecs[i].in2, vecs[i].bin,
                  vecs[i].diff, vecs[i].bout, vecs[i].ovf);
        end

        // Extra starts at k+3 (RUN) and k+9 (DONE) with new operands must be ignored.
        dcnt = 0;
        in1 = 8'h5A; in2 = 8'h3C; bin = 1'b0; start = 1'b1;
        tick();
        for (int j = 1; j <= 12; j++) begin
            start = (j == 3) || (j == 9);
            if (j >= 3) begin in1 = 8'hFF; in2 = 8'h00; end
            tick();
            if (done) dcnt++;
            if (j == W) begin
                chk("ign_done", 32'(done), 32'd1);
                chk("ign_diff", 32'(diff), 32'h1E);
                chk("ign_bout", 32'(bout), 32'd0);
            end
            if (j == 10) chk("ign_busy_k10", 32'(busy), 32'd0);
        end
        start = 1'b0;
        chk("ign_done_count", 32'(dcnt), 32'd1);
        $display("ignored-start sequence: done pulses=%0d diff=0x%02h", dcnt, diff);

        // Asynchronous reset between edges k+4 and k+5 aborts the operation.
        in1 = 8'h5A; in2 = 8'h3C; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 4; j++) tick();
        #2;
        sys_rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        chk("abort_ovf",  32'(ovf),  32'd0);
        tick();
        sys_rst = 1'b0;
        dcnt = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (done) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        $display("mid-run reset: outputs cleared, done pulses after=%0d", dcnt);
        do_op("post_rst", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);

        // Start held high with fresh random operands each cycle: accepts every W+2 edges.
        for (int j = 0; j < 4 * (W + 2); j++) begin
            start = 1'b1;
            in1 = W'($urandom); in2 = W'($urandom); bin = 1'($urandom);
            if (j % (W + 2) == 0) pend.push_back('{in1, in2, bin});
            tick();
            chk($sformatf("hold_done_j%0d", j), 32'(done), 32'(j % (W + 2) == W));
            if (done && pend.size() > 0) begin
                op = pend.pop_front();
                model(op.in1, op.in2, op.bin, ed, eb, eo);
                chk($sformatf("hold_diff_j%0d", j), 32'(diff), 32'(ed));
                chk($sformatf("hold_bout_j%0d", j), 32'(bout), 32'(eb));
                chk($sformatf("hold_ovf_j%0d", j),  32'(ovf),  32'(eo));
                $display("held-start result at j=%0d: 0x%02h - 0x%02h - %0d -> diff=0x%02h",
                         j, op.in1, op.in2, op.bin, diff);
            end
        end
        start = 1'b0;
        tick();
        tick();
        chk("hold_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rbi;
            ra  = W'($urandom);
            rb  = W'($urandom);
            rbi = 1'($urandom);
            model(ra, rb, rbi, ed, eb, eo);
            do_op($sformatf("rnd%0d", i), ra, rb, rbi, ed, eb, eo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
